// File: rtl/cluster_frame_tx.sv
// Buffers merged-cluster frames in a small FIFO and serializes them as 16-bit link words:
// a header, then one word per leading valid cluster. Define CLUSTER_TX_CHECKSUM_EN for an XOR trailer word.
module cluster_frame_tx #(
    parameter int FRAME_DEPTH = 4,
    parameter int NCLUSTERS   = 8
) (
    input  logic        clock4x,
    input  logic        reset,
    input  logic        latch_in,
    input  logic [10:0] adr0,
    input  logic [10:0] adr1,
    input  logic [10:0] adr2,
    input  logic [10:0] adr3,
    input  logic [10:0] adr4,
    input  logic [10:0] adr5,
    input  logic [10:0] adr6,
    input  logic [10:0] adr7,
    input  logic [2:0]  cnt0,
    input  logic [2:0]  cnt1,
    input  logic [2:0]  cnt2,
    input  logic [2:0]  cnt3,
    input  logic [2:0]  cnt4,
    input  logic [2:0]  cnt5,
    input  logic [2:0]  cnt6,
    input  logic [2:0]  cnt7,
    output logic [15:0] word_out,
    output logic        word_valid,
    input  logic        word_ready,
    output logic        overflow,
    output logic [15:0] overflow_cnt,
    input  logic        overflow_clr
);
    localparam int PW = $clog2(FRAME_DEPTH);

    typedef struct packed {
        logic [7:0]                 bx;
        logic [3:0]                 n;
        logic [NCLUSTERS-1:0][2:0]  cnt;
        logic [NCLUSTERS-1:0][10:0] adr;
    } frame_t;

`ifdef CLUSTER_TX_CHECKSUM_EN
    typedef enum logic [1:0] {IDLE, HDR, CLU, TRL} state_t;
    logic [15:0] cs_q, cs_d;
`else
    typedef enum logic [1:0] {IDLE, HDR, CLU} state_t;
`endif

    state_t      state_q, state_d;
    logic [2:0]  k_q, k_d;
    logic [15:0] word_out_q, word_out_d;
    logic        word_valid_q, word_valid_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PW:0]   count_q, count_d;
    logic [7:0]  bx_q, bx_d;
    logic        overflow_q, overflow_d;
    logic [15:0] overflow_cnt_q, overflow_cnt_d;
    frame_t      mem_q [FRAME_DEPTH];

    frame_t      wr_entry, head, next_head;
    logic [NCLUSTERS-1:0][10:0] adr_in;
    logic [NCLUSTERS-1:0][2:0]  cnt_in;
    logic [3:0]  n_in;
    logic        stop, full, push, drop, pop, accept, last_acc;

    function automatic logic [15:0] hdr_word(input frame_t f);
        return {4'b1000, f.bx, f.n};
    endfunction

    function automatic logic [15:0] clu_word(input frame_t f, input logic [2:0] k);
        return {2'b01, f.cnt[k], f.adr[k]};
    endfunction

    // Capture side: count leading valid slots and manage FIFO occupancy / drop accounting.
    always_comb begin
        adr_in = {adr7, adr6, adr5, adr4, adr3, adr2, adr1, adr0};
        cnt_in = {cnt7, cnt6, cnt5, cnt4, cnt3, cnt2, cnt1, cnt0};
        n_in   = '0;
        stop   = 1'b0;
        for (int i = 0; i < NCLUSTERS; i++) begin
            if (!stop && adr_in[i] < 11'd1536) n_in = n_in + 4'd1;
            else stop = 1'b1;
        end
        wr_entry.bx  = bx_q;
        wr_entry.n   = n_in;
        wr_entry.cnt = cnt_in;
        wr_entry.adr = adr_in;

        full = (count_q == (PW+1)'(FRAME_DEPTH));
        push = latch_in && !full;
        drop = latch_in && full;

        bx_d     = latch_in ? bx_q + 8'd1 : bx_q;
        wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
        count_d  = count_q + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};

        overflow_d     = overflow_clr ? 1'b0 : overflow_q;
        overflow_cnt_d = overflow_clr ? 16'd0 : overflow_cnt_q;
        if (drop) begin
            overflow_d = 1'b1;
            if (overflow_cnt_d != 16'hFFFF) overflow_cnt_d = overflow_cnt_d + 16'd1;
        end
    end

    assign head      = mem_q[rd_ptr_q];
    assign next_head = mem_q[rd_ptr_q + PW'(1)];
    assign accept    = word_valid_q && word_ready;

    // Output FSM: the state names the word currently held in word_out_q.
    always_comb begin
        state_d      = state_q;
        k_d          = k_q;
        word_out_d   = word_out_q;
        word_valid_d = word_valid_q;
        pop          = 1'b0;
        last_acc     = 1'b0;
`ifdef CLUSTER_TX_CHECKSUM_EN
        cs_d         = cs_q;
`endif
        case (state_q)
            IDLE: if (count_q != '0) begin
                state_d      = HDR;
                word_out_d   = hdr_word(head);
                word_valid_d = 1'b1;
            end
            HDR: if (accept) begin
                if (head.n != 4'd0) begin
                    state_d    = CLU;
                    k_d        = 3'd0;
                    word_out_d = clu_word(head, 3'd0);
                end else last_acc = 1'b1;
            end
            CLU: if (accept) begin
                if ({1'b0, k_q} + 4'd1 == head.n) last_acc = 1'b1;
                else begin
                    k_d        = k_q + 3'd1;
                    word_out_d = clu_word(head, k_q + 3'd1);
                end
            end
`ifdef CLUSTER_TX_CHECKSUM_EN
            TRL: if (accept) pop = 1'b1;
`endif
            default: state_d = IDLE;
        endcase
`ifdef CLUSTER_TX_CHECKSUM_EN
        if (state_q == IDLE) cs_d = '0;
        else if (accept && state_q != TRL) cs_d = cs_q ^ word_out_q;
        if (last_acc) begin
            state_d    = TRL;
            word_out_d = {2'b11, cs_d[13:0]};
        end
`else
        pop = last_acc;
`endif
        // Chain straight into the next buffered frame so there is no idle gap.
        if (pop) begin
            if (count_q > (PW+1)'(1)) begin
                state_d      = HDR;
                word_out_d   = hdr_word(next_head);
                word_valid_d = 1'b1;
`ifdef CLUSTER_TX_CHECKSUM_EN
                cs_d         = '0;
`endif
            end else begin
                state_d      = IDLE;
                word_out_d   = '0;
                word_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clock4x) begin
        if (push) mem_q[wr_ptr_q] <= wr_entry;
    end

    always_ff @(posedge clock4x) begin
        if (reset) begin
            state_q        <= IDLE;
            k_q            <= '0;
            word_out_q     <= '0;
            word_valid_q   <= 1'b0;
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            count_q        <= '0;
            bx_q           <= '0;
            overflow_q     <= 1'b0;
            overflow_cnt_q <= '0;
`ifdef CLUSTER_TX_CHECKSUM_EN
            cs_q           <= '0;
`endif
        end else begin
            state_q        <= state_d;
            k_q            <= k_d;
            word_out_q     <= word_out_d;
            word_valid_q   <= word_valid_d;
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            count_q        <= count_d;
            bx_q           <= bx_d;
            overflow_q     <= overflow_d;
            overflow_cnt_q <= overflow_cnt_d;
`ifdef CLUSTER_TX_CHECKSUM_EN
            cs_q           <= cs_d;
`endif
        end
    end

    assign word_out     = word_out_q;
    assign word_valid   = word_valid_q;
    assign overflow     = overflow_q;
    assign overflow_cnt = overflow_cnt_q;

endmodule

// File: tb/tb_cluster_frame_tx.sv
// Directed self-checking bench for cluster_frame_tx; honours CLUSTER_TX_CHECKSUM_EN for trailer words.
module tb_cluster_frame_tx;
    logic        clock4x = 1'b0;
    logic        reset, latch_in, word_ready, overflow_clr;
    logic [10:0] adr [8];
    logic [2:0]  cnt [8];
    logic [15:0] word_out, overflow_cnt;
    logic        word_valid, overflow;
    int          total = 0;
    int          bad = 0;
    logic [15:0] got_q[$];
    logic [15:0] exp_q[$];
`ifdef CLUSTER_TX_CHECKSUM_EN
    localparam int FLEN = 10;
`else
    localparam int FLEN = 9;
`endif

    always #5 clock4x = ~clock4x;

    cluster_frame_tx dut (
        .clock4x(clock4x), .reset(reset), .latch_in(latch_in),
        .adr0(adr[0]), .adr1(adr[1]), .adr2(adr[2]), .adr3(adr[3]),
        .adr4(adr[4]), .adr5(adr[5]), .adr6(adr[6]), .adr7(adr[7]),
        .cnt0(cnt[0]), .cnt1(cnt[1]), .cnt2(cnt[2]), .cnt3(cnt[3]),
        .cnt4(cnt[4]), .cnt5(cnt[5]), .cnt6(cnt[6]), .cnt7(cnt[7]),
        .word_out(word_out), .word_valid(word_valid), .word_ready(word_ready),
        .overflow(overflow), .overflow_cnt(overflow_cnt), .overflow_clr(overflow_clr)
    );

    always @(posedge clock4x) if (!reset && word_valid && word_ready) got_q.push_back(word_out);

    task automatic step(input int n);
        repeat (n) @(negedge clock4x);
    endtask

    task automatic apply_reset;
        reset = 1'b1; latch_in = 1'b0; overflow_clr = 1'b0;
        step(1);
        reset = 1'b0;
    endtask

    task automatic pulse_latch;
        latch_in = 1'b1;
        step(1);
        latch_in = 1'b0;
    endtask

    task automatic set_full(input int s);
        for (int i = 0; i < 8; i++) begin
            adr[i] = 11'(s * 16 + i * 100 + 1);
            cnt[i] = 3'(i + s);
        end
    endtask

    task automatic wait_words(input int target, input int budget, output bit ok);
        int t = 0;
        while (got_q.size() < target && t < budget) begin step(1); t++; end
        ok = (got_q.size() >= target);
    endtask

    // Reference frame builder straight from the word formats.
    task automatic model_frame(input logic [7:0] bx);
        int n = 0;
        bit stop = 0;
        logic [15:0] w, cs;
        for (int i = 0; i < 8; i++) begin
            if (!stop && adr[i] < 11'd1536) n++;
            else stop = 1;
        end
        w = {4'b1000, bx, 4'(n)};
        exp_q.push_back(w);
        cs = w;
        for (int i = 0; i < n; i++) begin
            w = {2'b01, cnt[i], adr[i]};
            exp_q.push_back(w);
            cs = cs ^ w;
        end
`ifdef CLUSTER_TX_CHECKSUM_EN
        exp_q.push_back({2'b11, cs[13:0]});
`endif
    endtask

    task automatic test_reset;
        reset = 1'b1; latch_in = 1'b0; overflow_clr = 1'b0; word_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin adr[i] = 11'd2047; cnt[i] = 3'd0; end
        step(2);
        reset = 1'b0;
        total++; if (word_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b exp=0", word_valid); end
        total++; if (word_out !== 16'h0) begin bad++; $display("FAIL rst_word got=%h exp=0000", word_out); end
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL rst_ovf got=%b exp=0", overflow); end
        total++; if (overflow_cnt !== 16'h0) begin bad++; $display("FAIL rst_ovfcnt got=%h exp=0000", overflow_cnt); end
        step(3);
        total++; if (word_valid !== 1'b0) begin bad++; $display("FAIL rst_empty got=%b exp=0", word_valid); end
    endtask

    task automatic test_basic;
        logic [15:0] e [5];
        int ne;
        e[0] = 16'h8003; e[1] = 16'h4005; e[2] = 16'h5864; e[3] = 16'h7DFF; e[4] = 16'hE59D;
`ifdef CLUSTER_TX_CHECKSUM_EN
        ne = 5;
`else
        ne = 4;
`endif
        apply_reset();
        word_ready = 1'b1;
        adr[0] = 11'd5;    cnt[0] = 3'd0;
        adr[1] = 11'd100;  cnt[1] = 3'd3;
        adr[2] = 11'd1535; cnt[2] = 3'd7;
        adr[3] = 11'd1536; adr[4] = 11'd10; adr[5] = 11'd20; adr[6] = 11'd30; adr[7] = 11'd40;
        pulse_latch();
        total++; if (word_valid !== 1'b0) begin bad++; $display("FAIL basic_t1 got=%b exp=0", word_valid); end
        for (int i = 0; i < ne; i++) begin
            step(1);
            total++;
            if (word_valid !== 1'b1 || word_out !== e[i]) begin
                bad++; $display("FAIL basic_w%0d got=%b/%h exp=1/%h", i, word_valid, word_out, e[i]);
            end
        end
        step(1);
        total++; if (word_valid !== 1'b0 || word_out !== 16'h0) begin bad++; $display("FAIL basic_idle got=%b/%h exp=0/0000", word_valid, word_out); end
    endtask

    task automatic test_empty_frame;
        int gb;
        bit ok;
        apply_reset();
        word_ready = 1'b1;
        gb = got_q.size();
        for (int i = 0; i < 8; i++) adr[i] = 11'(1536 + i);
        adr[5] = 11'd3;
        exp_q.delete();
`ifdef CLUSTER_TX_CHECKSUM_EN
        exp_q = '{16'h8000, 16'hC000, 16'h8010, 16'hC010};
`else
        exp_q = '{16'h8000, 16'h8010};
`endif
        pulse_latch();
        step(5);
        pulse_latch();
        wait_words(gb + exp_q.size(), 20, ok);
        step(4);
        total++; if (got_q.size() != gb + exp_q.size()) begin bad++; $display("FAIL n0_count got=%0d exp=%0d", got_q.size() - gb, exp_q.size()); end
        for (int i = 0; i < exp_q.size(); i++) begin
            total++;
            if (gb + i >= got_q.size() || got_q[gb+i] !== exp_q[i]) begin
                bad++; $display("FAIL n0_w%0d got=%h exp=%h", i, (gb + i < got_q.size()) ? got_q[gb+i] : 16'hxxxx, exp_q[i]);
            end
        end
    endtask

    task automatic test_gap_slot;
        int gb;
        bit ok;
        apply_reset();
        word_ready = 1'b1;
        gb = got_q.size();
        for (int i = 0; i < 8; i++) begin adr[i] = 11'(200 + i); cnt[i] = 3'd1; end
        adr[0] = 11'd7; cnt[0] = 3'd2; adr[1] = 11'd1600; adr[2] = 11'd9;
        exp_q.delete();
`ifdef CLUSTER_TX_CHECKSUM_EN
        exp_q = '{16'h8001, 16'h5007, 16'hD006};
`else
        exp_q = '{16'h8001, 16'h5007};
`endif
        pulse_latch();
        wait_words(gb + exp_q.size(), 20, ok);
        step(4);
        total++; if (got_q.size() != gb + exp_q.size()) begin bad++; $display("FAIL gap_count got=%0d exp=%0d", got_q.size() - gb, exp_q.size()); end
        for (int i = 0; i < exp_q.size(); i++) begin
            total++;
            if (gb + i >= got_q.size() || got_q[gb+i] !== exp_q[i]) begin
                bad++; $display("FAIL gap_w%0d got=%h exp=%h", i, (gb + i < got_q.size()) ? got_q[gb+i] : 16'hxxxx, exp_q[i]);
            end
        end
    endtask

    task automatic test_overflow;
        int gb;
        bit ok;
        apply_reset();
        word_ready = 1'b0;
        gb = got_q.size();
        exp_q.delete();
        for (int f = 0; f < 6; f++) begin
            set_full(f);
            if (f < 4) model_frame(8'(f));
            pulse_latch();
            step(7);
            total++;
            if (f > 0 && (word_valid !== 1'b1 || word_out !== 16'h8008)) begin
                bad++; $display("FAIL ovf_hold%0d got=%b/%h exp=1/8008", f, word_valid, word_out);
            end else if (f == 0 && word_out !== 16'h8008) begin
                bad++; $display("FAIL ovf_hdr0 got=%h exp=8008", word_out);
            end
        end
        total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_flag got=%b exp=1", overflow); end
        total++; if (overflow_cnt !== 16'd2) begin bad++; $display("FAIL ovf_cnt got=%0d exp=2", overflow_cnt); end
        word_ready = 1'b1;
        wait_words(gb + exp_q.size(), 100, ok);
        set_full(9);
        model_frame(8'd6);
        pulse_latch();
        wait_words(gb + exp_q.size(), 40, ok);
        step(3);
        total++; if (got_q.size() != gb + exp_q.size()) begin bad++; $display("FAIL ovf_count got=%0d exp=%0d", got_q.size() - gb, exp_q.size()); end
        for (int i = 0; i < exp_q.size(); i++) begin
            total++;
            if (gb + i >= got_q.size() || got_q[gb+i] !== exp_q[i]) begin
                bad++; $display("FAIL ovf_w%0d got=%h exp=%h", i, (gb + i < got_q.size()) ? got_q[gb+i] : 16'hxxxx, exp_q[i]);
            end
        end
        total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_sticky got=%b exp=1", overflow); end
    endtask

    task automatic test_random_stall;
        int gb;
        bit ok;
        logic        pv, pr;
        logic [15:0] pw;
        apply_reset();
        gb = got_q.size();
        exp_q.delete();
        pv = 1'b0; pr = 1'b1; pw = '0;
        for (int f = 0; f < 12; f++) begin
            for (int c = 0; c < 20; c++) begin
                if (pv && !pr) begin
                    total++;
                    if (word_valid !== 1'b1 || word_out !== pw) begin
                        bad++; $display("FAIL rnd_hold f%0d c%0d got=%b/%h exp=1/%h", f, c, word_valid, word_out, pw);
                    end
                end
                word_ready = ($urandom_range(0, 3) != 0);
                latch_in = (c == 0);
                if (c == 0) begin
                    for (int i = 0; i < 8; i++) begin
                        adr[i] = 11'($urandom_range(0, 1700));
                        cnt[i] = 3'($urandom_range(0, 7));
                    end
                    model_frame(8'(f));
                end
                pv = word_valid; pw = word_out; pr = word_ready;
                step(1);
            end
        end
        latch_in = 1'b0;
        word_ready = 1'b1;
        wait_words(gb + exp_q.size(), 200, ok);
        step(3);
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL rnd_noovf got=%b exp=0", overflow); end
        total++; if (got_q.size() != gb + exp_q.size()) begin bad++; $display("FAIL rnd_count got=%0d exp=%0d", got_q.size() - gb, exp_q.size()); end
        for (int i = 0; i < exp_q.size(); i++) begin
            total++;
            if (gb + i >= got_q.size() || got_q[gb+i] !== exp_q[i]) begin
                bad++; $display("FAIL rnd_w%0d got=%h exp=%h", i, (gb + i < got_q.size()) ? got_q[gb+i] : 16'hxxxx, exp_q[i]);
            end
        end
    endtask

    task automatic test_reset_midframe;
        int gb;
        bit ok;
        apply_reset();
        word_ready = 1'b1;
        gb = got_q.size();
        set_full(1);
        pulse_latch();
        step(7);
        set_full(2);
        pulse_latch();
        wait_words(gb + FLEN + 2, 60, ok);
        total++; if (!ok) begin bad++; $display("FAIL mid_timeout got=%0d exp=%0d", got_q.size() - gb, FLEN + 2); end
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        total++; if (word_valid !== 1'b0 || word_out !== 16'h0) begin bad++; $display("FAIL mid_rst got=%b/%h exp=0/0000", word_valid, word_out); end
        step(5);
        total++; if (word_valid !== 1'b0) begin bad++; $display("FAIL mid_tail got=%b exp=0", word_valid); end
        set_full(3);
        pulse_latch();
        step(1);
        total++; if (word_valid !== 1'b1 || word_out !== 16'h8008) begin bad++; $display("FAIL mid_bx0 got=%b/%h exp=1/8008", word_valid, word_out); end
        step(FLEN + 2);
    endtask

    task automatic test_ovf_clr;
        apply_reset();
        word_ready = 1'b0;
        set_full(4);
        latch_in = 1'b1;
        step(5);
        latch_in = 1'b0;
        total++; if (overflow !== 1'b1 || overflow_cnt !== 16'd1) begin bad++; $display("FAIL clr_drop1 got=%b/%0d exp=1/1", overflow, overflow_cnt); end
        latch_in = 1'b1; overflow_clr = 1'b1;
        step(1);
        latch_in = 1'b0; overflow_clr = 1'b0;
        total++; if (overflow !== 1'b1 || overflow_cnt !== 16'd1) begin bad++; $display("FAIL clr_same got=%b/%0d exp=1/1", overflow, overflow_cnt); end
        overflow_clr = 1'b1;
        step(1);
        overflow_clr = 1'b0;
        total++; if (overflow !== 1'b0 || overflow_cnt !== 16'd0) begin bad++; $display("FAIL clr_only got=%b/%0d exp=0/0", overflow, overflow_cnt); end
        word_ready = 1'b1;
        step(4 * FLEN + 4);
        total++; if (word_valid !== 1'b0) begin bad++; $display("FAIL clr_drain got=%b exp=0", word_valid); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_empty_frame();
        test_gap_slot();
        test_overflow();
        test_random_stall();
        test_reset_midframe();
        test_ovf_clr();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
